hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage (F/D/E/M/W) N-bit core; sits beside the condition unit and the pipeline registers.
- Generates forwarding selects, load-use stalls and branch flushes.
- Sequences the multi-cycle execute unit (MUL/DIV) by holding F/D/E and injecting bubbles into M until the result is ready.

Parameters:
- REG_AW, 4, register-address width.
- MC_LAT, 4, multi-cycle op latency in cycles; legal range 2..15.
- PC_REG, 15, register index never forwarded (PC).

Ports:
- CLK  in  1  core clock
- Reset  in  1  synchronous, active-high reset
- RA1D, RA2D  in  REG_AW  source regs of instr in Decode
- RA1E, RA2E  in  REG_AW  source regs of instr in Execute
- WA3E, WA3M, WA3W  in  REG_AW  dest regs in E/M/W
- RegWriteM, RegWriteW  in  1  dest write enables in M/W
- MemtoRegE  in  1  instr in E is a load
- BranchTakenE  in  1  branch resolved taken in E (condition-qualified)
- MultiCycleE  in  1  instr in E is multi-cycle
- CondExE  in  1  condition passed for instr in E
- ForwardAE, ForwardBE  out  2  operand A/B select: 00 regfile, 01 W result, 10 M result
- StallF, StallD, StallE  out  1  hold PC, D reg, E reg
- FlushD, FlushE, FlushM  out  1  bubble into D/E/M reg
- MCBusy  out  1  multi-cycle op in progress
- MCDoneE  out  1  multi-cycle result valid this cycle

Behaviour:
- Forwarding (combinational), per operand X in {A,B}: 10 if RegWriteM & RAXE==WA3M & RAXE!=PC_REG; else 01 if RegWriteW & RAXE==WA3W & RAXE!=PC_REG; else 00. M wins over W on a double match.
- LdStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- FSM in sub-module, states IDLE, BUSY; down-counter cnt, width 4.
  - IDLE -> BUSY when MultiCycleE & CondExE; cnt loads MC_LAT-2.
  - BUSY: cnt decrements each cycle. At cnt==0, MCDoneE=1 for one cycle and the next state is IDLE.
  - A multi-cycle instr with CondExE=0 never enters BUSY and takes 1 cycle.
- MCBusy = (state==BUSY) | (IDLE & MultiCycleE & CondExE). It is asserted in the start cycle.
- MCHold = MCBusy & ~MCDoneE.
- StallF = StallD = LdStall | MCHold.
- StallE = MCHold.
- FlushM = MCHold (bubble into M while E held).
- FlushD = BranchTakenE & ~MCHold.
- FlushE = (LdStall | BranchTakenE) & ~MCHold. E is never flushed while held.
- Total E occupancy of an executed multi-cycle op = MC_LAT cycles. The E reg advances in the MCDoneE cycle.
- Reset (sync) while BUSY: next state IDLE, cnt=0.
- While Reset=1:
  - StallF/StallD/StallE=0, FlushD=FlushE=FlushM=1.
  - ForwardAE=ForwardBE=00, MCBusy=0, MCDoneE=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs StallCycles[31:0] and FlushCount[31:0]:
  - StallCycles counts cycles with StallF=1.
  - FlushCount counts cycles with FlushE=1 and Reset=0.
  - Both saturate at 32'hFFFF_FFFF and are cleared by Reset.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mc_state_t enum: IDLE, BUSY.
  - Constant MC_CNT_W=4.
- Sub-module mc_sequencer: FSM plus down-counter; outputs MCBusy and MCDoneE.
- Forwarding and stall/flush logic stay in hazard_ctrl.

Test Plan:
1. Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=WA3M=15 -> 00.
2. Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0 for exactly 1 cycle.
3. Multi-cycle with MC_LAT=4: MultiCycleE=CondExE=1 at cycle t -> StallE=FlushM=1 in t..t+2, MCDoneE=1 at t+3, StallE=0 at t+3.
4. Multi-cycle with CondExE=0 -> MCBusy never 1, no stalls.
5. BranchTakenE=1 while MCHold=1 -> FlushD=FlushE=0. With the unit idle -> FlushD=FlushE=1.
6. Reset asserted at t+1 of a MC_LAT=4 op -> next cycle MCBusy=0, state IDLE. A new MultiCycleE after reset runs the full 4 cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned MC_CNT_W = 4;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    // A hit on the M stage outranks a hit on the W stage because M holds the younger result.
    function automatic fwd_sel_t fwd_sel(input logic matchM, input logic matchW);
        if (matchM) begin
            return FWD_MEM;
        end else if (matchW) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave is the controller.
import hazard_pkg::*;

interface hazard_ctrl_if #(parameter int unsigned REG_AW = 4);
    logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E;
    logic [REG_AW-1:0] WA3E, WA3M, WA3W;
    logic              RegWriteM, RegWriteW;
    logic              MemtoRegE, BranchTakenE, MultiCycleE, CondExE;
    fwd_sel_t          ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE;
    logic              FlushD, FlushE, FlushM;
    logic              MCBusy, MCDoneE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       StallCycles, FlushCount;
`endif

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MultiCycleE, CondExE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, MCBusy, MCDoneE
`ifdef HAZARD_PERF_CNT_EN
        , input StallCycles, FlushCount
`endif
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MultiCycleE, CondExE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, MCBusy, MCDoneE
`ifdef HAZARD_PERF_CNT_EN
        , output StallCycles, FlushCount
`endif
    );

endinterface

// File: rtl/hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: tracks a MUL/DIV occupying E and flags its final cycle.
module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic MultiCycleE,
    input  logic CondExE,
    output logic MCBusy,
    output logic MCDoneE
);

    mc_state_t             state, stateNext;
    logic [MC_CNT_W-1:0]   cnt, cntNext;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The start cycle counts as the first of MC_LAT, and the done cycle as the last.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        MCBusy    = 1'b0;
        MCDoneE   = 1'b0;
        case (state)
            IDLE: begin
                if (MultiCycleE && CondExE) begin
                    stateNext = BUSY;
                    cntNext   = MC_CNT_W'(MC_LAT - 2);
                    MCBusy    = 1'b1;
                end
            end
            BUSY: begin
                MCBusy = 1'b1;
                if (cnt == '0) begin
                    MCDoneE   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - MC_CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        if (Reset) begin
            MCBusy  = 1'b0;
            MCDoneE = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch flush, MUL/DIV hold.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned PC_REG = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

    logic ldStall;
    logic mcBusy, mcDone, mcHold;

    mc_sequencer #(
        .MC_LAT (MC_LAT)
    ) uSeq (
        .CLK         (CLK),
        .Reset       (Reset),
        .MultiCycleE (hz.MultiCycleE),
        .CondExE     (hz.CondExE),
        .MCBusy      (mcBusy),
        .MCDoneE     (mcDone)
    );

    assign ldStall = hz.MemtoRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    assign mcHold  = mcBusy && !mcDone;

    // E is frozen while the multi-cycle unit holds it, so E-stage flushes are suppressed.
    always_comb begin
        hz.ForwardAE = fwd_sel(hz.RegWriteM && (hz.RA1E == hz.WA3M) && (hz.RA1E != PC_IDX),
                               hz.RegWriteW && (hz.RA1E == hz.WA3W) && (hz.RA1E != PC_IDX));
        hz.ForwardBE = fwd_sel(hz.RegWriteM && (hz.RA2E == hz.WA3M) && (hz.RA2E != PC_IDX),
                               hz.RegWriteW && (hz.RA2E == hz.WA3W) && (hz.RA2E != PC_IDX));
        hz.StallF    = ldStall || mcHold;
        hz.StallD    = ldStall || mcHold;
        hz.StallE    = mcHold;
        hz.FlushM    = mcHold;
        hz.FlushD    = hz.BranchTakenE && !mcHold;
        hz.FlushE    = (ldStall || hz.BranchTakenE) && !mcHold;
        hz.MCBusy    = mcBusy;
        hz.MCDoneE   = mcDone;
        if (Reset) begin
            hz.ForwardAE = FWD_REG;
            hz.ForwardBE = FWD_REG;
            hz.StallF    = 1'b0;
            hz.StallD    = 1'b0;
            hz.StallE    = 1'b0;
            hz.FlushD    = 1'b1;
            hz.FlushE    = 1'b1;
            hz.FlushM    = 1'b1;
            hz.MCBusy    = 1'b0;
            hz.MCDoneE   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles, flushCount;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (hz.StallF && (stallCycles != 32'hFFFF_FFFF)) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (hz.FlushE && (flushCount != 32'hFFFF_FFFF)) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end

    assign hz.StallCycles = stallCycles;
    assign hz.FlushCount  = flushCount;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for combinational paths, sequences for MUL/DIV and reset.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic CLK;
    logic Reset;
    int   nTests;
    int   nFail;

    hazard_ctrl_if #(.REG_AW(4)) hif ();

    hazard_ctrl #(
        .REG_AW (4),
        .MC_LAT (4),
        .PC_REG (15)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .hz    (hif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy, MCDoneE}
    logic [11:0] outWord;
    assign outWord = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
                      hif.FlushD, hif.FlushE, hif.FlushM, hif.MCBusy, hif.MCDoneE};

    localparam logic [11:0] EXP_NONE  = 12'b00_00_000_000_00;
    localparam logic [11:0] EXP_HOLD  = 12'b00_00_111_001_10;
    localparam logic [11:0] EXP_DONE  = 12'b00_00_000_000_11;
    localparam logic [11:0] EXP_RESET = 12'b00_00_000_111_00;

    typedef struct {
        logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic        rwm, rww, ld, br, mc, cond;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                                input logic rwm, rww, ld, br, mc, cond,
                                input logic [11:0] exp);
        vec_t x;
        x.ra1d = ra1d; x.ra2d = ra2d; x.ra1e = ra1e; x.ra2e = ra2e;
        x.wa3e = wa3e; x.wa3m = wa3m; x.wa3w = wa3w;
        x.rwm = rwm; x.rww = rww; x.ld = ld; x.br = br; x.mc = mc; x.cond = cond;
        x.exp = exp;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        hif.RA1D = x.ra1d; hif.RA2D = x.ra2d; hif.RA1E = x.ra1e; hif.RA2E = x.ra2e;
        hif.WA3E = x.wa3e; hif.WA3M = x.wa3m; hif.WA3W = x.wa3w;
        hif.RegWriteM = x.rwm; hif.RegWriteW = x.rww; hif.MemtoRegE = x.ld;
        hif.BranchTakenE = x.br; hif.MultiCycleE = x.mc; hif.CondExE = x.cond;
    endtask

    task automatic clearIn();
        apply(mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NONE));
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b (FA FB sF sD sE fD fE fM busy done)", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One executed MC_LAT=4 op: three held cycles, then the done cycle, then idle.
    task automatic runMc(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            hif.MultiCycleE  = 1'b1;
            hif.CondExE      = 1'b1;
            hif.BranchTakenE = (i == 1);
            #1;
            check($sformatf("%s_cyc%0d", tag, i), outWord, (i < 3) ? EXP_HOLD : EXP_DONE);
        end
        @(negedge CLK);
        clearIn();
        #1;
        check($sformatf("%s_after", tag), outWord, EXP_NONE);
    endtask

    vec_t vecs[14];

    initial begin
        nTests = 0;
        nFail  = 0;
        Reset  = 1'b1;
        clearIn();

        //            ra1d  ra2d  ra1e  ra2e  wa3e  wa3m  wa3w  rwm   rww   ld    br    mc    cond
        vecs[0]  = mk(4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b10_00_000_000_00);
        vecs[1]  = mk(4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b01_00_000_000_00);
        vecs[2]  = mk(4'd0, 4'd0, 4'd15,4'd0, 4'd0, 4'd15,4'd15,1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NONE);
        vecs[3]  = mk(4'd0, 4'd0, 4'd2, 4'd7, 4'd0, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b10_01_000_000_00);
        vecs[4]  = mk(4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd4, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NONE);
        vecs[5]  = mk(4'd1, 4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b00_00_110_010_00);
        vecs[6]  = mk(4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'b00_00_110_010_00);
        vecs[7]  = mk(4'd6, 4'd7, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_NONE);
        vecs[8]  = mk(4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NONE);
        vecs[9]  = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'b00_00_000_110_00);
        vecs[10] = mk(4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'b00_00_110_110_00);
        vecs[11] = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_NONE);
        vecs[12] = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_NONE);
        vecs[13] = mk(4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'b00_10_000_000_00);

        // Reset forces safe outputs even with hazards and a multi-cycle start on the inputs.
        @(negedge CLK);
        apply(mk(4'd5, 4'd0, 4'd3, 4'd3, 4'd5, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, EXP_RESET));
        #1;
        check("reset_outputs", outWord, EXP_RESET);
        @(negedge CLK);
        Reset = 1'b0;
        clearIn();
        #1;
        check("post_reset_idle", outWord, EXP_NONE);

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), outWord, vecs[i].exp);
        end
        @(negedge CLK);
        clearIn();

        runMc("mc_a");

        // Reset one cycle into a multi-cycle op, then a fresh op must take the full latency.
        @(negedge CLK);
        hif.MultiCycleE = 1'b1;
        hif.CondExE     = 1'b1;
        #1;
        check("mc_b_start", outWord, EXP_HOLD);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("mc_b_in_reset", outWord, EXP_RESET);
        @(negedge CLK);
        Reset = 1'b0;
        clearIn();
        #1;
        check("mc_b_idle_after_reset", outWord, EXP_NONE);
`ifdef HAZARD_PERF_CNT_EN
        check32("perf_stall_cleared", hif.StallCycles, 32'd0);
        check32("perf_flush_cleared", hif.FlushCount, 32'd0);
`endif
        runMc("mc_c");
`ifdef HAZARD_PERF_CNT_EN
        check32("perf_stall_after_mc", hif.StallCycles, 32'd3);
        check32("perf_flush_after_mc", hif.FlushCount, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
